// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/MuxKey.sv
// Keyed multiplexer: returns the data of the entry whose key matches, else zero.
// Each lut entry is {key, data}; entry i occupies bits [(i+1)*(KEY_LEN+DATA_LEN)-1 : i*(KEY_LEN+DATA_LEN)].
module MuxKey #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  output logic [DATA_LEN-1:0]                  out,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  always_comb begin
    out = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) out = lut[i*PAIR_LEN +: DATA_LEN];
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin winner select: rotate requests so ptr sits at bit 0, take the
// lowest set bit, then rotate the index back by adding ptr.
module rr_pick #(
  parameter int NR_REQ = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NR_REQ-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  logic [2*NR_REQ-1:0] dbl;
  logic [NR_REQ-1:0]   rot;
  logic [SEL_W-1:0]    enc;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NR_REQ-1:0];

  always_comb begin
    enc = '0;
    for (int i = NR_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = SEL_W'(i);
    end
  end

  // NR_REQ is a power of two, so the modular add wraps for free.
  assign idx = ptr + enc;
  assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter/sequencer: grants one requester per burst, drives the
// shared mux select and steers the valid/ready handshake to the downstream port.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NR_REQ    = 4,
  parameter int SEL_W     = 2,
  parameter int DATA_W    = 2,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NR_REQ-1:0]        req_valid,
  input  logic [NR_REQ-1:0]        req_last,
  input  logic [NR_REQ*DATA_W-1:0] req_data,
  output logic [NR_REQ-1:0]        req_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         sel,
  output logic [NR_REQ-1:0]        grant_oh,
  output logic                     busy
);

  localparam int                PAIR_W  = SEL_W + DATA_W;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST - 1);

  state_t                    state, state_nxt;
  logic [SEL_W-1:0]          rr_ptr, rr_ptr_nxt, sel_nxt, pick_idx;
  logic [NR_REQ-1:0]         grant_nxt;
  logic [CNT_W-1:0]          beat_cnt, beat_cnt_nxt;
  logic                      pick_any, at_max, xfer, release_now;
  logic [NR_REQ*PAIR_W-1:0]  lut;
  logic [DATA_W-1:0]         mux_data;

  rr_pick #(.NR_REQ(NR_REQ), .SEL_W(SEL_W)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    lut = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      lut[i*PAIR_W +: PAIR_W] = {SEL_W'(i), req_data[i*DATA_W +: DATA_W]};
    end
  end

  MuxKey #(.NR_KEY(NR_REQ), .KEY_LEN(SEL_W), .DATA_LEN(DATA_W)) u_mux (
    .out (mux_data),
    .key (sel),
    .lut (lut)
  );

  assign busy        = (state == BUSY);
  assign at_max      = (beat_cnt == CNT_MAX);
  assign out_valid   = busy & req_valid[sel];
  assign out_data    = mux_data;
  assign out_last    = out_valid & (req_last[sel] | at_max);
  assign xfer        = out_valid & out_ready;
  assign release_now = xfer & (req_last[sel] | at_max);

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[sel] = out_ready;
  end

  always_comb begin
    // NOTE: every signal gets its hold value first, so no branch leaves one unassigned and no latch is inferred.
    state_nxt    = state;
    sel_nxt      = sel;
    grant_nxt    = grant_oh;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt    = BUSY;
          sel_nxt      = pick_idx;
          grant_nxt    = NR_REQ'(1) << pick_idx;
          beat_cnt_nxt = '0;
        end
      end
      BUSY: begin
        if (xfer) beat_cnt_nxt = beat_cnt + CNT_W'(1);
        if (release_now) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = sel + SEL_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values and updates together.
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      sel      <= '0;
      grant_oh <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      sel      <= sel_nxt;
      grant_oh <= grant_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: per-requester beat streams feed the DUT,
// a scoreboard holds the expected data/last per requester, plus directed cycle checks.
module tb_rr_mux_arbiter;

  localparam int NR_REQ    = 4;
  localparam int SEL_W     = 2;
  localparam int DATA_W    = 2;
  localparam int MAX_BURST = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NR_REQ-1:0]        req_valid;
  logic [NR_REQ-1:0]        req_last;
  logic [NR_REQ*DATA_W-1:0] req_data;
  logic [NR_REQ-1:0]        req_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic                     out_ready;
  logic [SEL_W-1:0]         sel;
  logic [NR_REQ-1:0]        grant_oh;
  logic                     busy;

  always #5 clk = ~clk;

  rr_mux_arbiter #(
    .NR_REQ(NR_REQ), .SEL_W(SEL_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .grant_oh  (grant_oh),
    .busy      (busy)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t             strm  [NR_REQ][$];
  beat_t             exp_q [NR_REQ][$];
  int                pos   [NR_REQ];
  logic [SEL_W-1:0]  got_grants[$];
  logic [NR_REQ-1:0] gap;
  logic [NR_REQ-1:0] xfer_seen;
  logic              ready_ctl, rst_ctl, rst_seen, prev_busy;
  int                n_checks = 0;
  int                n_fail   = 0;
  int                n_xfer   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected out_last: the requester's own last flag, or the MAX_BURST-th beat of a grant.
  function automatic void push_exp(input int r, input beat_t b);
    beat_t e;
    e.data = b.data;
    e.last = b.last || (pos[r] == MAX_BURST - 1);
    if (e.last) pos[r] = 0;
    else        pos[r]++;
    exp_q[r].push_back(e);
  endfunction

  task automatic add_stream(input int r, input int n, input bit last_end, input int base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = DATA_W'(base + k);
      b.last = (k == n - 1) && last_end;
      strm[r].push_back(b);
      push_exp(r, b);
    end
  endtask

  task automatic reseed();
    for (int r = 0; r < NR_REQ; r++) begin
      exp_q[r].delete();
      pos[r] = 0;
      for (int k = 0; k < strm[r].size(); k++) push_exp(r, strm[r][k]);
    end
  endtask

  task automatic drive();
    rst_n     = rst_ctl;
    out_ready = ready_ctl;
    for (int r = 0; r < NR_REQ; r++) begin
      if (strm[r].size() > 0 && !gap[r]) begin
        req_valid[r]                  = 1'b1;
        req_data[r*DATA_W +: DATA_W]  = strm[r][0].data;
        req_last[r]                   = strm[r][0].last;
      end else begin
        req_valid[r]                  = 1'b0;
        req_data[r*DATA_W +: DATA_W]  = '0;
        req_last[r]                   = 1'b0;
      end
    end
  endtask

  task automatic sample();
    beat_t e;
    xfer_seen = '0;
    rst_seen  = !rst_n;
    if (rst_n) begin
      check("ready_onehot", $countones(req_ready) <= 1, 1);
      for (int r = 0; r < NR_REQ; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          xfer_seen[r] = 1'b1;
          n_xfer++;
          check("xfer_sel", sel, r);
          check("out_valid", out_valid, 1);
          check("sb_nonempty", exp_q[r].size() > 0, 1);
          if (exp_q[r].size() > 0) begin
            e = exp_q[r].pop_front();
            check("out_data", out_data, e.data);
            check("out_last", out_last, e.last);
          end
        end
      end
    end
    if (busy && !prev_busy) got_grants.push_back(sel);
    prev_busy = busy;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int r = 0; r < NR_REQ; r++) begin
      if (xfer_seen[r]) void'(strm[r].pop_front());
    end
    if (rst_seen) reseed();
    drive();
    @(negedge clk);
    sample();
  endtask

  function automatic bit pending();
    for (int r = 0; r < NR_REQ; r++) begin
      if (strm[r].size() > 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while ((pending() || busy) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_done", n < budget, 1);
  endtask

  task automatic do_reset();
    rst_ctl = 1'b0;
    cycle();
    cycle();
    rst_ctl = 1'b1;
    cycle();
    got_grants.delete();
  endtask

  int  fair_exp  [5] = '{0, 1, 2, 3, 0};
  int  force_exp [5] = '{0, 1, 2, 3, 1};
  bit  bp_pat    [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int  x0;

  initial begin
    rst_ctl   = 1'b0;
    ready_ctl = 1'b0;
    gap       = '0;
    xfer_seen = '0;
    rst_seen  = 1'b0;
    prev_busy = 1'b0;
    for (int r = 0; r < NR_REQ; r++) pos[r] = 0;
    drive();

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_grant", grant_oh, 0);
    check("rst_sel", sel, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rr_ptr", dut.rr_ptr, 0);
    check("rst_beat_cnt", dut.beat_cnt, 0);

    // Basic grant to requester 2
    add_stream(2, 1, 1'b1, 3);
    ready_ctl = 1'b1;
    cycle();
    check("basic_idle_busy", busy, 0);
    cycle();
    check("basic_grant", grant_oh, 4'b0100);
    check("basic_sel", sel, 2);
    check("basic_data", out_data, 2'b11);
    check("basic_last", out_last, 1);
    cycle();
    check("basic_rel_busy", busy, 0);
    check("basic_rel_grant", grant_oh, 0);
    check("basic_rel_ptr", dut.rr_ptr, 3);
    check("basic_rel_sel", sel, 2);

    // Fairness: all requesters with two single-beat bursts each
    do_reset();
    for (int r = 0; r < NR_REQ; r++) begin
      add_stream(r, 1, 1'b1, r);
      add_stream(r, 1, 1'b1, r + 1);
    end
    for (int i = 0; i < 10; i++) cycle();
    check("fair_grants", got_grants.size(), 5);
    for (int k = 0; k < 5 && k < got_grants.size(); k++) check("fair_sel", got_grants[k], fair_exp[k]);
    drain(200);

    // Forced release after MAX_BURST beats of requester 1
    do_reset();
    add_stream(0, 1, 1'b1, 1);
    add_stream(1, 12, 1'b1, 0);
    add_stream(2, 1, 1'b1, 2);
    add_stream(3, 1, 1'b1, 3);
    drain(300);
    check("force_grants", got_grants.size(), 5);
    for (int k = 0; k < 5 && k < got_grants.size(); k++) check("force_sel", got_grants[k], force_exp[k]);

    // Backpressure on requester 0
    do_reset();
    add_stream(0, 3, 1'b1, 1);
    ready_ctl = 1'b0;
    cycle();
    cycle();
    check("bp_grant", grant_oh, 4'b0001);
    x0 = n_xfer;
    for (int i = 0; i < 4; i++) begin
      ready_ctl = bp_pat[i];
      cycle();
      check("bp_req_ready", req_ready, {3'b000, bp_pat[i]});
    end
    ready_ctl = 1'b0;
    cycle();
    check("bp_xfers", n_xfer - x0, 2);
    check("bp_beat_cnt", dut.beat_cnt, 2);
    check("bp_busy", busy, 1);
    ready_ctl = 1'b1;
    drain(100);

    // Reset during beat 3 of requester 3
    do_reset();
    add_stream(3, 6, 1'b1, 0);
    cycle();
    cycle();
    cycle();
    rst_ctl = 1'b0;
    cycle();
    rst_ctl = 1'b1;
    cycle();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", grant_oh, 0);
    check("mid_rst_sel", sel, 0);
    check("mid_rst_ptr", dut.rr_ptr, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_beat_cnt", dut.beat_cnt, 0);
    drain(100);

    // Valid gap mid-burst on requester 2 while requester 1 waits
    do_reset();
    add_stream(2, 6, 1'b1, 0);
    cycle();
    cycle();
    cycle();
    gap[2] = 1'b1;
    add_stream(1, 1, 1'b1, 1);
    x0 = n_xfer;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("gap_grant", grant_oh, 4'b0100);
      check("gap_out_valid", out_valid, 0);
      check("gap_busy", busy, 1);
      check("gap_beat_cnt", dut.beat_cnt, 2);
    end
    check("gap_no_xfer", n_xfer - x0, 0);
    gap = '0;
    drain(100);
    check("gap_grants", got_grants.size(), 2);
    if (got_grants.size() >= 2) begin
      check("gap_first", got_grants[0], 2);
      check("gap_second", got_grants[1], 1);
    end

    for (int r = 0; r < NR_REQ; r++) check("sb_drained", exp_q[r].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and sequencer for the 4-way, 2-bit keyed multiplexer datapath. Up to four requesters compete for one shared output channel. The block grants one requester at a time, holds the grant for a burst of beats, and drives the mux select. It also steers the valid/ready handshake between the winner and the downstream consumer.

## Interface
- `NR_REQ`, default 4: number of requesters; must be a power of two.
- `SEL_W`, default 2: select width, equal to log2(`NR_REQ`).
- `DATA_W`, default 2: beat width per requester.
- `MAX_BURST`, default 8: maximum beats per grant before forced release; range 1..255.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in `NR_REQ`: per-requester beat valid.
- `req_last` in `NR_REQ`: per-requester last-beat-of-burst flag; qualified by `req_valid`.
- `req_data` in `NR_REQ*DATA_W`: flat data bus; requester i occupies bits [DATA_W*(i+1)-1 : DATA_W*i].
- `req_ready` out `NR_REQ`: per-requester ready; at most one bit is set.
- `out_valid` out 1: downstream beat valid.
- `out_data` out `DATA_W`: downstream beat data.
- `out_last` out 1: downstream last flag. It is set on a requester's last beat and also on a forced-release beat.
- `out_ready` in 1: downstream ready.
- `sel` out `SEL_W`: registered select for the shared mux; holds the current or most recent grant.
- `grant_oh` out `NR_REQ`: one-hot current grant; all zero when idle.
- `busy` out 1: set while in state BUSY.

## Operation
- State IDLE:
  - If any `req_valid` bit is set, pick the first requester at or after `rr_ptr` in ascending, wrapping order.
  - Register the pick in `sel` and `grant_oh`, clear `beat_cnt`, and go to BUSY.
  - If no request is present, stay in IDLE.
- State BUSY, combinational steering from the grant g:
  - `out_valid` = `req_valid`[g].
  - `out_data` = `req_data` slice g.
  - `req_ready`[g] = `out_ready`; all other `req_ready` bits are 0.
- A beat transfers when `out_valid` and `out_ready` are both set.
- On each transfer, `beat_cnt` increments.
- Release happens on a transfer where either `req_last`[g] is set or `beat_cnt` equals `MAX_BURST`-1. On release:
  - Go to IDLE and clear `grant_oh`.
  - Set `rr_ptr` = (g+1) mod `NR_REQ`.
  - `sel` keeps g.
- `out_last` = `req_valid`[g] & (`req_last`[g] | `beat_cnt` == `MAX_BURST`-1).
- Requester drops `req_valid` mid-burst: the grant is held. `out_valid` goes low and no timeout applies.
- Forced release splits the burst. The requester re-arbitrates, and its later beats form a new grant.
- `beat_cnt` is 8 bits wide and never wraps, because release occurs at `MAX_BURST`-1.
- Requests arriving during BUSY are ignored until the next IDLE cycle. No pre-emption.
- If `req_valid`, `req_data` or `req_last` of the granted requester changes without a transfer, the output follows combinationally. Stability is the requester's obligation.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `sel`=0, `grant_oh`=0, `beat_cnt`=0, `busy`=0. Consequently `out_valid`=0, `out_last`=0 and `req_ready`=0.
- Arbitration latency is 1 cycle. A request sampled in IDLE at edge N gives grant and `busy` after edge N; the first beat can transfer in cycle N+1.
- After release there is one idle bubble cycle before the next grant. Steady-state throughput is (burst length)/(burst length + 1).
- Zero combinational path from `req_valid` to `grant_oh`/`sel`; both are registered.
- There is a combinational path from `out_ready` to `req_ready`, and from the granted `req_*` inputs to `out_*`.
- Reset asserted mid-burst: on the next edge all state returns to its reset values. Any beat in flight that cycle is dropped, with no transfer credited.

## Structure
- Package `rr_arb_pkg`: a state enum (IDLE, BUSY) and the `beat_cnt` width constant (8).
- Sub-module `rr_pick`: a combinational rotate, priority-encode, rotate-back block that takes `req_valid` and `rr_ptr` and returns the winner index and an any-request flag.
- Data steering reuses the existing MuxKey with `NR_REQ` keys, `SEL_W` key width and `DATA_W` data width, keyed by `sel`.

## Test plan
- **Basic grant:** release `rst_n`, then raise `req_valid`=4'b0100 with `req_data` slice 2 = 2'b11, `req_last`[2]=1 and `out_ready`=1.
  - Next cycle: `grant_oh`=4'b0100, `sel`=2, `out_data`=2'b11, `out_last`=1.
  - Cycle after: IDLE, `rr_ptr`=3.
- **Fairness:** hold all `req_valid` set, single-beat bursts with `req_last`=1, `out_ready`=1.
  - `sel` sequence is 0,1,2,3,0, with a one-cycle gap between grants.
- **Forced release:** `MAX_BURST`=8, requester 1 streams 12 beats with `req_last`=0.
  - `out_last` rises on beat 8, then IDLE.
  - A regrant to 1 follows only after the other pending requesters have been served.
- **Backpressure:** granted requester 0, `out_ready` toggles 1,0,0,1.
  - Exactly 2 transfers, `beat_cnt`=2, `req_ready`[0] mirrors `out_ready`, other `req_ready` bits stay 0.
- **Reset mid-burst:** assert `rst_n`=0 during beat 3 of requester 3.
  - After the edge: `busy`=0, `grant_oh`=0, `sel`=0, `rr_ptr`=0, `req_ready`=0.
- **Valid gap:** granted requester drops `req_valid` for 3 cycles mid-burst.
  - `grant_oh` is held, `out_valid`=0, `beat_cnt` unchanged, no grant to other requesters.
